// File: rtl/xoodyak_block_feeder.sv
// Packs a 32-bit valid/ready message stream into rate-sized Xoodyak blocks and
// presents each block with its opmode to the core for exactly OP_CLKS cycles.
module xoodyak_block_feeder #(
  parameter int OP_CLKS     = 4,
  parameter int RKIN_BYTES  = 44,
  parameter int RKOUT_BYTES = 24
) (
  input  logic         eph1,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_last,
  input  logic [3:0]   in_mode,
  output logic [351:0] input_data,
  output logic [4:0]   opmode,
  output logic         blk_valid,
  output logic [5:0]   blk_len,
  output logic         blk_last
);

  localparam int          CW     = (OP_CLKS > 1) ? $clog2(OP_CLKS) : 1;
  localparam logic [5:0]  CAP_IN = 6'(RKIN_BYTES);
  localparam logic [5:0]  CAP_OUT = 6'(RKOUT_BYTES);
  localparam logic [CW-1:0] CNT_END = CW'(OP_CLKS - 1);

  typedef enum logic {FILL, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [351:0]    buf_q, buf_d;
  logic [5:0]      ptr_q, ptr_d;
  logic [3:0]      mode_q, mode_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic            rdy_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept, msg_start, short_wd;
  logic [3:0]      mode_eff;
  logic [5:0]      cap;
  logic [2:0]      nb;
  logic [31:0]     wmask;
  logic [351:0]    word_sh;

  always_comb begin
    accept    = in_valid & rdy_q;
    // A message begins on the first word of a first block; nothing is buffered yet.
    msg_start = first_q && (ptr_q == 6'd0);
    mode_eff  = msg_start ? in_mode : mode_q;
    cap       = (mode_eff == 4'd4 || mode_eff == 4'd5) ? CAP_OUT : CAP_IN;
    short_wd  = (in_bytes < 3'd4) && !in_last;
    nb        = (in_bytes >= 3'd4 || short_wd) ? 3'd4 : in_bytes;
    case (nb)
      3'd0:    wmask = 32'h0;
      3'd1:    wmask = {in_data[31:24], 24'h0};
      3'd2:    wmask = {in_data[31:16], 16'h0};
      3'd3:    wmask = {in_data[31:8], 8'h0};
      default: wmask = in_data;
    endcase
    // Buffer is cleared between blocks, so OR-ing the shifted word places it.
    word_sh   = {wmask, 320'h0} >> {ptr_q, 3'b000};

    state_d = state_q;
    buf_d   = buf_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    first_d = first_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          buf_d = buf_q | word_sh;
          ptr_d = ptr_q + {3'b000, nb};
          if (msg_start) mode_d = in_mode;
          if (short_wd)  err_d  = 1'b1;
          if (in_last)   last_d = 1'b1;
          if (ptr_d == cap || in_last) begin
            state_d = ISSUE;
            cnt_d   = '0;
          end
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_END) begin
          state_d = FILL;
          buf_d   = '0;
          ptr_d   = '0;
          first_d = last_q;
          last_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      buf_q   <= '0;
      ptr_q   <= '0;
      mode_q  <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == FILL);
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    in_ready   = rdy_q;
    blk_valid  = (state_q == ISSUE);
    input_data = blk_valid ? buf_q : '0;
    opmode     = blk_valid ? {~first_q, mode_q} : 5'h00;
    blk_len    = blk_valid ? ptr_q : 6'd0;
    blk_last   = blk_valid & last_q;
  end

endmodule
